mac_multiplex_seq: RTL

Window sequencer wrapped around the multiplex MAC. It accepts a precision mode and an operation count, then gates operand pairs into the MAC through a valid/ready handshake. It clears the accumulator at the start of each window, flushes the MAC's two-stage pipeline, and unpacks the final accumulator word into sign-extended per-lane results behind a valid/ready output. It drives the MAC's `w`, `a`, `config_aw` and `accu_rst` inputs and consumes its `z`; `config_sc` is produced by a separate static decoder from `cfg_q`.

---
 rtl/mac_multiplex_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mac_multiplex_seq.sv
// Window sequencer for the multiplex MAC: accepts a mode and length, gates operand
// pairs into the MAC, flushes its two-stage pipeline and unpacks per-lane results.
module mac_multiplex_seq #(
  parameter int W_WIDTH         = 8,
  parameter int A_WIDTH         = 8,
  parameter int PLUS_WIDTH      = 4,
  parameter int CONFIG_AW_WIDTH = 2,
  parameter int LEN_WIDTH       = 8,
  localparam int Z_WIDTH        = W_WIDTH + A_WIDTH + 4 * PLUS_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  output logic                         start_ready_o,
  input  logic [CONFIG_AW_WIDTH-1:0]   cfg_aw_i,
  input  logic [LEN_WIDTH-1:0]         len_i,
  input  logic                         op_valid_i,
  output logic                         op_ready_o,
  input  logic [W_WIDTH-1:0]           op_w_i,
  input  logic [A_WIDTH-1:0]           op_a_i,
  output logic [W_WIDTH-1:0]           mac_w_o,
  output logic [A_WIDTH-1:0]           mac_a_o,
  output logic [CONFIG_AW_WIDTH-1:0]   mac_config_aw_o,
  output logic                         mac_accu_rst_o,
  input  logic [Z_WIDTH-1:0]           mac_z_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [4*Z_WIDTH-1:0]         res_lanes_o,
  output logic [CONFIG_AW_WIDTH-1:0]   res_mode_o,
  output logic                         err_cfg_o,
  output logic [1:0]                   dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where both valid and ready
  // are high; valid never waits on ready, and data is held stable while valid is high.

  localparam int HALF    = Z_WIDTH / 2;
  localparam int QUARTER = Z_WIDTH / 4;

  localparam logic [CONFIG_AW_WIDTH-1:0] MODE_8B  = CONFIG_AW_WIDTH'(2'b00);
  localparam logic [CONFIG_AW_WIDTH-1:0] MODE_4B  = CONFIG_AW_WIDTH'(2'b01);
  localparam logic [CONFIG_AW_WIDTH-1:0] MODE_BAD = CONFIG_AW_WIDTH'(2'b10);
  localparam logic [CONFIG_AW_WIDTH-1:0] MODE_2B  = CONFIG_AW_WIDTH'(2'b11);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [LEN_WIDTH-1:0]         cnt_q, cnt_d;
  logic [CONFIG_AW_WIDTH-1:0]   cfg_q, cfg_d;
  logic                         accu_rst_q, accu_rst_d;
  logic                         err_q, err_d;
  logic                         flush_q, flush_d;
  logic [4*Z_WIDTH-1:0]         lanes_q, lanes_d;
  logic [CONFIG_AW_WIDTH-1:0]   mode_q, mode_d;
  logic [4*Z_WIDTH-1:0]         unpacked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cfg_q      <= '0;
      accu_rst_q <= 1'b0;
      err_q      <= 1'b0;
      flush_q    <= 1'b0;
      lanes_q    <= '0;
      mode_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
      accu_rst_q <= accu_rst_d;
      err_q      <= err_d;
      flush_q    <= flush_d;
      lanes_q    <= lanes_d;
      mode_q     <= mode_d;
    end
  end

  // Sign-extend each accumulator slice of the final MAC word into its own lane.
  always_comb begin
    unpacked = '0;
    case (cfg_q)
      MODE_8B: unpacked[Z_WIDTH-1:0] = mac_z_i;
      MODE_4B: begin
        for (int i = 0; i < 2; i++) begin
          unpacked[i*Z_WIDTH +: Z_WIDTH] =
            {{(Z_WIDTH-HALF){mac_z_i[i*HALF+HALF-1]}}, mac_z_i[i*HALF +: HALF]};
        end
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          unpacked[i*Z_WIDTH +: Z_WIDTH] =
            {{(Z_WIDTH-QUARTER){mac_z_i[i*QUARTER+QUARTER-1]}}, mac_z_i[i*QUARTER +: QUARTER]};
        end
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_d      = cfg_q;
    accu_rst_d = 1'b0;
    err_d      = 1'b0;
    flush_d    = flush_q;
    lanes_d    = lanes_q;
    mode_d     = mode_q;
    op_ready_o = 1'b0;
    mac_w_o    = '0;
    mac_a_o    = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            err_d = 1'b1;
          end else begin
            err_d      = (cfg_aw_i == MODE_BAD);
            cfg_d      = (cfg_aw_i == MODE_BAD) ? MODE_2B : cfg_aw_i;
            cnt_d      = len_i;
            accu_rst_d = 1'b1;
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        op_ready_o = 1'b1;
        if (op_valid_i) begin
          mac_w_o = op_w_i;
          mac_a_o = op_a_i;
          cnt_d   = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = S_FLUSH;
            flush_d = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) begin
          lanes_d = unpacked;
          mode_d  = cfg_q;
          flush_d = 1'b0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign start_ready_o   = (state_q == S_IDLE);
  assign res_valid_o     = (state_q == S_OUT);
  assign mac_config_aw_o = cfg_q;
  assign mac_accu_rst_o  = accu_rst_q;
  assign err_cfg_o       = err_q;
  assign res_lanes_o     = lanes_q;
  assign res_mode_o      = mode_q;
  assign dbg_state_o     = state_q;

endmodule
